// File: rtl/gshare_bht_if.sv
// Fetch/execute-side bundle for the gshare branch predictor: IF lookup,
// registered prediction return, and EX training/repair.
interface gshare_bht_if #(
   parameter int IDX_W = 8,
   parameter int GHR_W = 8
);
   logic             rd_en;
   logic [31:0]      pc_if;
   logic             predict_taken;
   logic [IDX_W-1:0] predict_idx;
   logic [GHR_W-1:0] predict_ghr;
   logic             update_en;
   logic             taken;
   logic [IDX_W-1:0] update_idx;
   logic [GHR_W-1:0] update_ghr;
   logic             mispredict;

   modport master (
      output rd_en, pc_if, update_en, taken, update_idx, update_ghr, mispredict,
      input  predict_taken, predict_idx, predict_ghr
   );

   modport slave (
      input  rd_en, pc_if, update_en, taken, update_idx, update_ghr, mispredict,
      output predict_taken, predict_idx, predict_ghr
   );
endinterface

// File: rtl/gshare_bht.sv
// Gshare direction predictor: saturating counters indexed by PC ^ speculative
// global history, trained and history-repaired from EX.
module gshare_bht #(
   parameter int DEPTH = 256,
   parameter int CNT_W = 2,
   parameter int GHR_W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   gshare_bht_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [DEPTH];
   logic [GHR_W-1:0] ghr_q;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_bit;
   logic             taken_p1;
   logic [IDX_W-1:0] idx_p1;
   logic [GHR_W-1:0] ghr_p1;
   logic             unused_pc;

   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic up);
      if (up)
         return (c == CNT_MAX) ? c : c + CNT_W'(1);
      return (c == '0) ? c : c - CNT_W'(1);
   endfunction

   // Truncating the concatenation drops the oldest bit; also covers GHR_W=1.
   function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] h,
                                                 input logic b);
      return GHR_W'({h, b});
   endfunction

   assign rd_idx    = bus.pc_if[1 +: IDX_W] ^ IDX_W'(ghr_q);
   assign rd_bit    = cnt_q[rd_idx][CNT_W-1];
   assign unused_pc = ^{bus.pc_if[31:IDX_W+1], bus.pc_if[0]};

   // Stage p0 -> p1: table lookup, registered prediction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         taken_p1 <= 1'b0;
         idx_p1   <= '0;
         ghr_p1   <= '0;
      end else if (bus.rd_en) begin
         taken_p1 <= rd_bit;
         idx_p1   <= rd_idx;
         ghr_p1   <= ghr_q;
      end
   end

   // Repair from EX outranks the speculative shift of a same-cycle lookup
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ghr_q <= '0;
      else if (bus.update_en && bus.mispredict)
         ghr_q <= shift_in(bus.update_ghr, bus.taken);
      else if (bus.rd_en)
         ghr_q <= shift_in(ghr_q, rd_bit);
   end

   // Training write; a same-cycle lookup reads the old value (no bypass)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            cnt_q[i] <= CNT_RST;
      end else if (bus.update_en) begin
         cnt_q[bus.update_idx] <= sat_step(cnt_q[bus.update_idx], bus.taken);
      end
   end

   assign bus.predict_taken = taken_p1;
   assign bus.predict_idx   = idx_p1;
   assign bus.predict_ghr   = ghr_p1;
endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: default config, GHR_W=1, and CNT_W=3/DEPTH=16.
module tb_gshare_bht;
   logic clk = 1'b0;
   logic reset_n;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   gshare_bht_if #(.IDX_W(8), .GHR_W(8)) bus_a ();
   gshare_bht_if #(.IDX_W(8), .GHR_W(1)) bus_b ();
   gshare_bht_if #(.IDX_W(4), .GHR_W(4)) bus_c ();

   gshare_bht #(.DEPTH(256), .CNT_W(2), .GHR_W(8)) u_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
   gshare_bht #(.DEPTH(256), .CNT_W(2), .GHR_W(1)) u_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.slave));
   gshare_bht #(.DEPTH(16),  .CNT_W(3), .GHR_W(4)) u_c (.clk(clk), .reset_n(reset_n), .bus(bus_c.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_a.rd_en = 0; bus_a.pc_if = '0; bus_a.update_en = 0; bus_a.taken = 0;
      bus_a.update_idx = '0; bus_a.update_ghr = '0; bus_a.mispredict = 0;
      bus_b.rd_en = 0; bus_b.pc_if = '0; bus_b.update_en = 0; bus_b.taken = 0;
      bus_b.update_idx = '0; bus_b.update_ghr = '0; bus_b.mispredict = 0;
      bus_c.rd_en = 0; bus_c.pc_if = '0; bus_c.update_en = 0; bus_c.taken = 0;
      bus_c.update_idx = '0; bus_c.update_ghr = '0; bus_c.mispredict = 0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 0;
      tick();
      tick();
      reset_n = 1;
   endtask

   initial begin
      logic       pa, pb, outcome;
      logic [7:0] ia, ib, ga;
      logic       gb;
      int         miss_a, miss_b, e;
      int         exp_up[3] = '{2, 3, 3};
      int         exp_dn[4] = '{2, 1, 0, 0};

      // reset state
      idle();
      reset_n = 0;
      tick();
      tick();
      chk("rst_a_taken", bus_a.predict_taken, 0);
      chk("rst_a_idx", bus_a.predict_idx, 0);
      chk("rst_a_ghr", bus_a.predict_ghr, 0);
      chk("rst_c_taken", bus_c.predict_taken, 0);
      chk("rst_c_cnt", u_c.cnt_q[0], 3);
      reset_n = 1;

      // first lookup at pc 0x100
      bus_a.rd_en = 1; bus_a.pc_if = 32'h100;
      tick();
      chk("lk0_taken", bus_a.predict_taken, 0);
      chk("lk0_idx", bus_a.predict_idx, 8'h80);
      chk("lk0_ghr", bus_a.predict_ghr, 0);
      tick();
      chk("lk1_ghr", bus_a.predict_ghr, 0);
      chk("lk1_idx", bus_a.predict_idx, 8'h80);
      bus_a.rd_en = 0;
      chk("lk1_ghr_q", u_a.ghr_q, 0);

      // counter saturation at idx 5
      do_reset();
      bus_a.update_en = 1; bus_a.taken = 1; bus_a.update_idx = 8'd5;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("sat_up%0d", k), u_a.cnt_q[5], exp_up[k]);
      end
      bus_a.update_en = 0;
      bus_a.rd_en = 1; bus_a.pc_if = 32'h0A;
      tick();
      chk("sat_pred", bus_a.predict_taken, 1);
      chk("sat_idx", bus_a.predict_idx, 8'd5);
      bus_a.rd_en = 0;
      bus_a.update_en = 1; bus_a.taken = 0; bus_a.update_idx = 8'd5;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("sat_dn%0d", k), u_a.cnt_q[5], exp_dn[k]);
      end
      bus_a.update_en = 0;

      // history shift 1,1,0 then repair with same-cycle lookup
      do_reset();
      bus_a.update_en = 1; bus_a.taken = 1; bus_a.update_idx = 8'h10;
      tick();
      bus_a.update_idx = 8'h11;
      tick();
      bus_a.update_en = 0;
      bus_a.rd_en = 1; bus_a.pc_if = 32'h20;
      tick();
      chk("gh0_pred", bus_a.predict_taken, 1);
      chk("gh0_idx", bus_a.predict_idx, 8'h10);
      tick();
      chk("gh1_pred", bus_a.predict_taken, 1);
      chk("gh1_ghr", bus_a.predict_ghr, 8'h01);
      chk("gh1_idx", bus_a.predict_idx, 8'h11);
      tick();
      chk("gh2_pred", bus_a.predict_taken, 0);
      chk("gh2_ghr", bus_a.predict_ghr, 8'h03);
      chk("gh2_idx", bus_a.predict_idx, 8'h13);
      bus_a.update_en = 1; bus_a.mispredict = 1; bus_a.taken = 0;
      bus_a.update_ghr = 8'h0F; bus_a.update_idx = 8'h40;
      tick();
      chk("rep_old_ghr", bus_a.predict_ghr, 8'h06);
      chk("rep_old_idx", bus_a.predict_idx, 8'h16);
      chk("rep_ghr_q", u_a.ghr_q, 8'h1E);
      bus_a.update_en = 0; bus_a.mispredict = 0;
      tick();
      chk("rep_next_ghr", bus_a.predict_ghr, 8'h1E);
      chk("rep_next_idx", bus_a.predict_idx, 8'h0E);
      bus_a.rd_en = 0;

      // read/write collision: no bypass
      do_reset();
      bus_a.update_en = 1; bus_a.taken = 1; bus_a.update_idx = 8'h80;
      bus_a.rd_en = 1; bus_a.pc_if = 32'h100;
      tick();
      chk("col_same", bus_a.predict_taken, 0);
      chk("col_idx", bus_a.predict_idx, 8'h80);
      bus_a.update_en = 0;
      tick();
      chk("col_next", bus_a.predict_taken, 1);
      bus_a.rd_en = 0;

      // alternating T/N at a fixed PC, GHR_W=8 and GHR_W=1
      do_reset();
      outcome = 1; miss_a = 0; miss_b = 0;
      for (int it = 0; it < 24; it++) begin
         bus_a.rd_en = 1; bus_a.pc_if = 32'h300;
         bus_b.rd_en = 1; bus_b.pc_if = 32'h300;
         tick();
         pa = bus_a.predict_taken; ia = bus_a.predict_idx; ga = bus_a.predict_ghr;
         pb = bus_b.predict_taken; ib = bus_b.predict_idx; gb = bus_b.predict_ghr;
         if (it >= 20) begin
            if (pa != outcome) miss_a++;
            if (pb != outcome) miss_b++;
         end
         bus_a.rd_en = 0; bus_b.rd_en = 0;
         bus_a.update_en = 1; bus_a.taken = outcome; bus_a.update_idx = ia;
         bus_a.update_ghr = ga; bus_a.mispredict = (pa != outcome);
         bus_b.update_en = 1; bus_b.taken = outcome; bus_b.update_idx = ib;
         bus_b.update_ghr = gb; bus_b.mispredict = (pb != outcome);
         tick();
         bus_a.update_en = 0; bus_a.mispredict = 0;
         bus_b.update_en = 0; bus_b.mispredict = 0;
         outcome = ~outcome;
      end
      chk("alt_a_late_miss", miss_a, 0);
      chk("alt_b_late_miss", miss_b, 0);

      // CNT_W=3, DEPTH=16: saturation and mid-stream reset
      do_reset();
      chk("c_rst_cnt", u_c.cnt_q[3], 3);
      bus_c.update_en = 1; bus_c.taken = 1; bus_c.update_idx = 4'd3;
      for (int k = 0; k < 8; k++) begin
         tick();
         e = (4 + k > 7) ? 7 : 4 + k;
         chk($sformatf("c_up%0d", k), u_c.cnt_q[3], e);
      end
      bus_c.update_en = 0;
      bus_c.rd_en = 1; bus_c.pc_if = 32'h6;
      tick();
      chk("c_pred", bus_c.predict_taken, 1);
      chk("c_idx", bus_c.predict_idx, 4'd3);
      #2 reset_n = 0;
      #1;
      chk("c_mid_taken", bus_c.predict_taken, 0);
      chk("c_mid_idx", bus_c.predict_idx, 0);
      chk("c_mid_ghr", bus_c.predict_ghr, 0);
      chk("c_mid_cnt", u_c.cnt_q[3], 3);
      tick();
      reset_n = 1;
      tick();
      chk("c_post_pred", bus_c.predict_taken, 0);
      chk("c_post_idx", bus_c.predict_idx, 4'd3);
      chk("c_post_ghr", bus_c.predict_ghr, 0);
      bus_c.rd_en = 0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
